// File: rtl/kim_mips_pkg.sv
// Shared types and constants for the MIPS execute stage.
// ALU op decode lives here so every unit agrees on the encoding.
package kim_mips_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int MUL_CYCLES = DATA_W;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_ORI,
        ALU_SLT,
        ALU_MULT,
        ALU_MFHI,
        ALU_MFLO
    } alu_op_e;

    typedef enum logic {
        MUL_IDLE,
        MUL_RUN
    } mul_state_e;

    function automatic alu_op_e alu_decode(
        input logic [1:0] aluop,
        input logic [5:0] funct
    );
        alu_op_e op;
        op = ALU_NONE;
        case (aluop)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_ORI: op = ALU_ORI;
            default: begin
                case (funct)
                    F_ADD:   op = ALU_ADD;
                    F_SUB:   op = ALU_SUB;
                    F_AND:   op = ALU_AND;
                    F_OR:    op = ALU_OR;
                    F_SLT:   op = ALU_SLT;
                    F_MULT:  op = ALU_MULT;
                    F_MFHI:  op = ALU_MFHI;
                    F_MFLO:  op = ALU_MFLO;
                    default: op = ALU_NONE;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/kim_seq_mult.sv
// Sequential signed multiplier: magnitudes are shift-added for
// MUL_CYCLES steps, the sign is applied when HI/LO are written.
module kim_seq_mult
    import kim_mips_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_running,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    mul_state_e            r_state;
    mul_state_e            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_mcand;
    logic [2*DATA_W-1:0]   r_prod;
    logic                  r_sign;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;

    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W:0]       w_sum;
    logic [2*DATA_W-1:0]   w_prod_nxt;
    logic [2*DATA_W-1:0]   w_prod_fin;
    logic                  w_last;

    assign w_abs_a = i_a[DATA_W-1] ? -i_a : i_a;
    assign w_abs_b = i_b[DATA_W-1] ? -i_b : i_b;

    // Upper half accumulates; the multiplier drains out of the lower half.
    assign w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                 + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nxt = {w_sum, r_prod[DATA_W-1:1]};
    assign w_prod_fin = r_sign ? -w_prod_nxt : w_prod_nxt;
    assign w_last     = (r_cnt == CNT_W'(MUL_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MUL_IDLE: if (i_start) w_state_nxt = MUL_RUN;
            MUL_RUN:  if (w_last)  w_state_nxt = MUL_IDLE;
            default:  w_state_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= MUL_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_sign  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == MUL_IDLE && i_start) begin
                r_mcand <= w_abs_a;
                r_prod  <= {{DATA_W{1'b0}}, w_abs_b};
                r_sign  <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
                r_cnt   <= '0;
            end else if (r_state == MUL_RUN) begin
                r_prod <= w_prod_nxt;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_hi <= w_prod_fin[2*DATA_W-1:DATA_W];
                    r_lo <= w_prod_fin[DATA_W-1:0];
                end
            end
        end
    end

    assign o_running = (r_state == MUL_RUN);
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

endmodule

// File: rtl/kim_ex_mem_stage.sv
// Execute stage: forwarding, ALU, HI/LO multiplier and the EX/MEM
// register; HI/LO readers and new mults stall while the multiplier runs.
module kim_ex_mem_stage
    import kim_mips_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              RegDst,
    input  logic              MemtoReg,
    input  logic [1:0]        ALUOp,
    input  logic              MemWrite,
    input  logic              ALUSrc,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] r_data1,
    input  logic [DATA_W-1:0] r_data2,
    input  logic [DATA_W-1:0] se_in,
    input  logic [5:0]        funct_in,
    input  logic [ADDR_W-1:0] ID_EX_Rs,
    input  logic [ADDR_W-1:0] ID_EX_Rt,
    input  logic [ADDR_W-1:0] ID_EX_Rd,
    input  logic              wb_RegWrite,
    input  logic [ADDR_W-1:0] wb_w_reg,
    input  logic [DATA_W-1:0] wb_w_data,
    output logic              ex_busy,
    output logic              EX_MEM_RegWrite_reg,
    output logic              EX_MEM_MemtoReg_reg,
    output logic              EX_MEM_MemWrite_reg,
    output logic [DATA_W-1:0] EX_MEM_alu_reg,
    output logic [DATA_W-1:0] EX_MEM_wdata_reg,
    output logic [ADDR_W-1:0] EX_MEM_wreg_reg
);

    alu_op_e           w_op;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;
    logic              w_running;
    logic              w_is_mult;
    logic              w_hilo_use;
    logic              w_start;
    logic              w_exm_a;
    logic              w_wb_a;
    logic              w_exm_b;
    logic              w_wb_b;

    assign w_op = alu_decode(ALUOp, funct_in);

    assign w_exm_a = EX_MEM_RegWrite_reg && EX_MEM_wreg_reg != '0
                  && EX_MEM_wreg_reg == ID_EX_Rs;
    assign w_wb_a  = wb_RegWrite && wb_w_reg != '0
                  && wb_w_reg == ID_EX_Rs;
    assign w_exm_b = EX_MEM_RegWrite_reg && EX_MEM_wreg_reg != '0
                  && EX_MEM_wreg_reg == ID_EX_Rt;
    assign w_wb_b  = wb_RegWrite && wb_w_reg != '0
                  && wb_w_reg == ID_EX_Rt;

    assign w_fwd_a = w_exm_a ? EX_MEM_alu_reg
                   : w_wb_a  ? wb_w_data
                   : r_data1;
    assign w_fwd_b = w_exm_b ? EX_MEM_alu_reg
                   : w_wb_b  ? wb_w_data
                   : r_data2;
    assign w_opb   = ALUSrc ? se_in : w_fwd_b;

    assign w_is_mult  = (w_op == ALU_MULT);
    assign w_hilo_use = w_is_mult || w_op == ALU_MFHI
                     || w_op == ALU_MFLO;
    assign ex_busy    = w_running && w_hilo_use;
    assign w_start    = w_is_mult && !w_running;

    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_ADD:  w_result = w_fwd_a + w_opb;
            ALU_SUB:  w_result = w_fwd_a - w_opb;
            ALU_AND:  w_result = w_fwd_a & w_opb;
            ALU_OR:   w_result = w_fwd_a | w_opb;
            ALU_ORI:  w_result = w_fwd_a | {16'b0, se_in[15:0]};
            ALU_SLT:  w_result = {{(DATA_W-1){1'b0}},
                                  $signed(w_fwd_a) < $signed(w_opb)};
            ALU_MFHI: w_result = w_hi;
            ALU_MFLO: w_result = w_lo;
            default:  w_result = '0;
        endcase
    end

    kim_seq_mult u_mult (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (w_start),
        .i_a       (w_fwd_a),
        .i_b       (w_fwd_b),
        .o_running (w_running),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            EX_MEM_RegWrite_reg <= 1'b0;
            EX_MEM_MemtoReg_reg <= 1'b0;
            EX_MEM_MemWrite_reg <= 1'b0;
            EX_MEM_alu_reg      <= '0;
            EX_MEM_wdata_reg    <= '0;
            EX_MEM_wreg_reg     <= '0;
        end else if (ex_busy) begin
            EX_MEM_RegWrite_reg <= 1'b0;
            EX_MEM_MemtoReg_reg <= 1'b0;
            EX_MEM_MemWrite_reg <= 1'b0;
            EX_MEM_alu_reg      <= '0;
            EX_MEM_wdata_reg    <= '0;
            EX_MEM_wreg_reg     <= '0;
        end else begin
            EX_MEM_RegWrite_reg <= RegWrite && !w_is_mult;
            EX_MEM_MemtoReg_reg <= MemtoReg;
            EX_MEM_MemWrite_reg <= MemWrite;
            EX_MEM_alu_reg      <= w_result;
            EX_MEM_wdata_reg    <= w_fwd_b;
            EX_MEM_wreg_reg     <= RegDst ? ID_EX_Rd : ID_EX_Rt;
        end
    end

endmodule

// File: tb/tb_kim_ex_mem_stage.sv
// Scoreboard bench for the execute stage: directed pipeline
// scenarios followed by random instruction traffic.
module tb_kim_ex_mem_stage;

    typedef struct {
        logic        regdst, memtoreg, memwrite, alusrc, regwrite;
        logic [1:0]  aluop;
        logic [31:0] d1, d2, se;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd;
        logic        wbrw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
    } inst_t;

    typedef struct {
        logic        rw, mtr, mw;
        logic [31:0] alu, wdata;
        logic [4:0]  wreg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        RegDst, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [31:0] r_data1, r_data2, se_in, wb_w_data;
    logic [5:0]  funct_in;
    logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, wb_w_reg;
    logic        wb_RegWrite;
    logic        ex_busy;
    logic        EX_MEM_RegWrite_reg, EX_MEM_MemtoReg_reg;
    logic        EX_MEM_MemWrite_reg;
    logic [31:0] EX_MEM_alu_reg, EX_MEM_wdata_reg;
    logic [4:0]  EX_MEM_wreg_reg;

    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    exp_t q[$];

    exp_t        m_exm;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_left;

    kim_ex_mem_stage dut (
        .clk                 (clk),
        .rstn                (rstn),
        .RegDst              (RegDst),
        .MemtoReg            (MemtoReg),
        .ALUOp               (ALUOp),
        .MemWrite            (MemWrite),
        .ALUSrc              (ALUSrc),
        .RegWrite            (RegWrite),
        .r_data1             (r_data1),
        .r_data2             (r_data2),
        .se_in               (se_in),
        .funct_in            (funct_in),
        .ID_EX_Rs            (ID_EX_Rs),
        .ID_EX_Rt            (ID_EX_Rt),
        .ID_EX_Rd            (ID_EX_Rd),
        .wb_RegWrite         (wb_RegWrite),
        .wb_w_reg            (wb_w_reg),
        .wb_w_data           (wb_w_data),
        .ex_busy             (ex_busy),
        .EX_MEM_RegWrite_reg (EX_MEM_RegWrite_reg),
        .EX_MEM_MemtoReg_reg (EX_MEM_MemtoReg_reg),
        .EX_MEM_MemWrite_reg (EX_MEM_MemWrite_reg),
        .EX_MEM_alu_reg      (EX_MEM_alu_reg),
        .EX_MEM_wdata_reg    (EX_MEM_wdata_reg),
        .EX_MEM_wreg_reg     (EX_MEM_wreg_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] fb,
                                        inst_t x);
        if (m_exm.rw && m_exm.wreg != 0 && m_exm.wreg == r)
            return m_exm.alu;
        if (x.wbrw && x.wbr != 0 && x.wbr == r)
            return x.wbd;
        return fb;
    endfunction

    function automatic bit uses_hilo(inst_t x);
        return x.aluop == 2'b10 &&
               (x.funct == 6'h18 || x.funct == 6'h10 || x.funct == 6'h12);
    endfunction

    function automatic exp_t model(inst_t x);
        exp_t        e;
        logic [31:0] a, b, opb, r;
        a   = fwd(x.rs, x.d1, x);
        b   = fwd(x.rt, x.d2, x);
        opb = x.alusrc ? x.se : b;
        r   = 0;
        case (x.aluop)
            2'b00: r = a + opb;
            2'b01: r = a - opb;
            2'b11: r = a | (x.se & 32'h0000_FFFF);
            default:
                case (x.funct)
                    6'h20: r = a + opb;
                    6'h22: r = a - opb;
                    6'h24: r = a & opb;
                    6'h25: r = a | opb;
                    6'h2A: r = ($signed(a) < $signed(opb)) ? 1 : 0;
                    6'h10: r = m_hi;
                    6'h12: r = m_lo;
                    default: r = 0;
                endcase
        endcase
        e.rw    = x.regwrite && !(x.aluop == 2'b10 && x.funct == 6'h18);
        e.mtr   = x.memtoreg;
        e.mw    = x.memwrite;
        e.alu   = r;
        e.wdata = b;
        e.wreg  = x.regdst ? x.rd : x.rt;
        return e;
    endfunction

    task automatic drive(inst_t x);
        RegDst = x.regdst; MemtoReg = x.memtoreg; MemWrite = x.memwrite;
        ALUSrc = x.alusrc; RegWrite = x.regwrite; ALUOp = x.aluop;
        r_data1 = x.d1; r_data2 = x.d2; se_in = x.se; funct_in = x.funct;
        ID_EX_Rs = x.rs; ID_EX_Rt = x.rt; ID_EX_Rd = x.rd;
        wb_RegWrite = x.wbrw; wb_w_reg = x.wbr; wb_w_data = x.wbd;
    endtask

    task automatic model_reset();
        m_exm  = '{default: 0};
        m_hi   = 0;
        m_lo   = 0;
        m_pend = 0;
        m_left = 0;
    endtask

    // Presents one instruction, holding it while the stage reports busy.
    task automatic issue(inst_t x);
        int   guard;
        bit   busy;
        bit   start;
        exp_t e;
        logic [63:0] p;
        guard = 0;
        while (1) begin
            @(negedge clk);
            drive(x);
            #1;
            busy  = (m_left > 0) && uses_hilo(x);
            start = !busy && m_left == 0 &&
                    x.aluop == 2'b10 && x.funct == 6'h18;
            chk("ex_busy", {31'b0, ex_busy}, {31'b0, busy});
            if (busy) begin
                e = '{default: 0};
                busy_cnt++;
            end else begin
                e = model(x);
            end
            q.push_back(e);
            if (start) begin
                p = 64'(longint'($signed(fwd(x.rs, x.d1, x))) *
                        longint'($signed(fwd(x.rt, x.d2, x))));
                m_pend = p;
                m_left = 32;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                end
            end
            m_exm = e;
            if (!busy) break;
            guard++;
            if (guard > 100) begin
                chk("hold_timeout", 32'(guard), 32'd0);
                break;
            end
        end
    endtask

    task automatic post(string n, logic [31:0] exp);
        @(posedge clk);
        #2;
        chk(n, EX_MEM_alu_reg, exp);
    endtask

    function automatic inst_t rtype(logic [5:0] f, logic [4:0] rs,
                                    logic [4:0] rt, logic [4:0] rd,
                                    logic [31:0] d1, logic [31:0] d2);
        inst_t x;
        x = '{default: 0};
        x.regdst = 1; x.regwrite = 1; x.aluop = 2'b10; x.funct = f;
        x.rs = rs; x.rt = rt; x.rd = rd; x.d1 = d1; x.d2 = d2;
        return x;
    endfunction

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rstn && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_regwrite", {31'b0, EX_MEM_RegWrite_reg}, {31'b0, e.rw});
            chk("sb_memtoreg", {31'b0, EX_MEM_MemtoReg_reg}, {31'b0, e.mtr});
            chk("sb_memwrite", {31'b0, EX_MEM_MemWrite_reg}, {31'b0, e.mw});
            chk("sb_alu", EX_MEM_alu_reg, e.alu);
            chk("sb_wdata", EX_MEM_wdata_reg, e.wdata);
            chk("sb_wreg", {27'b0, EX_MEM_wreg_reg}, {27'b0, e.wreg});
        end
    end

    initial begin
        inst_t nop, x;
        logic [5:0] fl [9];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
               6'h18, 6'h10, 6'h12, 6'h3F};
        nop = '{default: 0};
        model_reset();
        drive(nop);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu", EX_MEM_alu_reg, 0);
        chk("rst_regwrite", {31'b0, EX_MEM_RegWrite_reg}, 0);
        chk("rst_busy", {31'b0, ex_busy}, 0);
        @(negedge clk);
        rstn = 1;

        issue(nop);
        issue(rtype(6'h20, 1, 2, 3, 5, 7));
        issue(rtype(6'h22, 3, 1, 4, 32'hBAD, 5));
        post("fwd_exmem", 7);

        issue(nop);
        issue(rtype(6'h20, 1, 2, 3, 5, 7));
        issue(nop);
        x = rtype(6'h22, 3, 1, 4, 32'hBAD, 5);
        x.wbrw = 1; x.wbr = 3; x.wbd = 12;
        issue(x);
        post("fwd_memwb", 7);

        issue(nop);
        issue(rtype(6'h20, 1, 2, 0, 50, 5));
        x = rtype(6'h20, 0, 0, 6, 0, 0);
        issue(x);
        post("no_fwd_r0", 0);

        issue(nop);
        issue(rtype(6'h20, 1, 2, 5, 4, 5));
        x = rtype(6'h20, 5, 0, 6, 32'hBAD, 0);
        x.wbrw = 1; x.wbr = 5; x.wbd = 4;
        issue(x);
        post("fwd_priority", 9);

        issue(nop);
        issue(rtype(6'h18, 1, 2, 0, -32'sd3, 100000));
        busy_cnt = 0;
        issue(rtype(6'h12, 0, 0, 7, 0, 0));
        chk("mult_busy_cycles", 32'(busy_cnt), 32);
        post("mult_lo", 32'(-300000));
        issue(rtype(6'h10, 0, 0, 8, 0, 0));
        post("mult_hi", 32'hFFFF_FFFF);

        issue(nop);
        issue(rtype(6'h2A, 1, 2, 9, 32'hFFFF_FFFF, 1));
        post("slt_neg", 1);
        x = '{default: 0};
        x.aluop = 2'b11; x.regwrite = 1; x.rt = 10;
        x.d1 = 32'h1234_0000; x.se = 32'hFFFF_8000;
        issue(x);
        post("ori_zext", 32'h1234_8000);

        issue(nop);
        x = '{default: 0};
        x.alusrc = 1; x.memwrite = 1; x.se = 8; x.d1 = 32'h100;
        x.rs = 1; x.rt = 2; x.wbrw = 1; x.wbr = 2; x.wbd = 32'hDEAD;
        issue(x);
        @(posedge clk);
        #2;
        chk("sw_alu", EX_MEM_alu_reg, 32'h108);
        chk("sw_wdata", EX_MEM_wdata_reg, 32'hDEAD);
        chk("sw_memwrite", {31'b0, EX_MEM_MemWrite_reg}, 1);
        chk("sw_regwrite", {31'b0, EX_MEM_RegWrite_reg}, 0);

        for (int i = 0; i < 400; i++) begin
            x = '{default: 0};
            x.regdst   = 1'($urandom);
            x.memtoreg = 1'($urandom);
            x.memwrite = 1'($urandom);
            x.alusrc   = 1'($urandom);
            x.regwrite = 1'($urandom);
            x.aluop    = 2'($urandom);
            x.funct    = fl[$urandom_range(0, 8)];
            if (x.funct == 6'h18 && $urandom_range(0, 3) != 0)
                x.funct = 6'h20;
            x.d1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            x.d2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            x.se = $urandom;
            x.rs = 5'($urandom_range(0, 3));
            x.rt = 5'($urandom_range(0, 3));
            x.rd = 5'($urandom_range(0, 3));
            x.wbrw = 1'($urandom);
            x.wbr  = 5'($urandom_range(0, 3));
            x.wbd  = $urandom;
            issue(x);
        end

        issue(rtype(6'h18, 1, 2, 0, 32'h8000_0000, 32'h7));
        issue(rtype(6'h20, 1, 2, 3, 1, 2));
        issue(rtype(6'h20, 1, 2, 3, 3, 4));
        @(posedge clk);
        #3;
        rstn = 0;
        model_reset();
        q.delete();
        drive(rtype(6'h12, 0, 0, 7, 0, 0));
        #1;
        chk("midrun_rst_alu", EX_MEM_alu_reg, 0);
        chk("midrun_rst_wreg", {27'b0, EX_MEM_wreg_reg}, 0);
        chk("midrun_rst_busy", {31'b0, ex_busy}, 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1;
        issue(rtype(6'h12, 0, 0, 7, 0, 0));
        post("midrun_rst_lo", 0);

        @(posedge clk);
        #3;
        chk("sb_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
